// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-granular sharing of one UART transmitter
//            between NUM_REQ byte producers. The current owner keeps the
//            UART until it sends the byte flagged last.
// Options  : UART_ARB_HDR_EN - prefix every message with the header byte
//            HDR_BASE + grant index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int           NUM_REQ  = 4,
  parameter int           N        = 8,
  parameter int           ID_W     = $clog2(NUM_REQ),
  parameter logic [N-1:0] HDR_BASE = 8'hA0
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*N-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [N-1:0]         tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_busy_i,
  output logic [ID_W-1:0]      grant_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3
`ifdef UART_ARB_HDR_EN
    ,
    S_HDR     = 3'd4
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_grant;
  logic [ID_W-1:0] w_grant_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            r_last;
  logic            w_last_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_start;
  logic            w_start_nxt;
  logic [N-1:0]    r_data;
  logic [N-1:0]    w_data_nxt;

  logic            w_any;
  logic [ID_W-1:0] w_pick;
  logic            w_owner_valid;
  logic            w_owner_last;
  logic [N-1:0]    w_owner_data;
  logic [ID_W-1:0] w_grant_inc;

  assign w_owner_valid = req_valid_i[r_grant];
  assign w_owner_last  = req_last_i[r_grant];
  assign w_owner_data  = req_data_i[int'(r_grant)*N +: N];
  // Pointer wraps explicitly so non power-of-two NUM_REQ never names an absent requester
  assign w_grant_inc   = (int'(r_grant) == NUM_REQ-1) ? '0 : r_grant + 1'b1;

`ifdef UART_ARB_HDR_EN
  logic [N-1:0] w_hdr_byte;
  assign w_hdr_byte = HDR_BASE + {{(N-ID_W){1'b0}}, r_grant};
`endif

  // Round-robin search: first valid requester at or after the pointer, wrapping
  always_comb begin
    int              v_idx;
    logic [ID_W-1:0] v_sel;
    w_any  = 1'b0;
    w_pick = '0;
    v_idx  = 0;
    v_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = int'(r_ptr) + i;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      v_sel = v_idx[ID_W-1:0];
      if (!w_any && req_valid_i[v_sel]) begin
        w_any  = 1'b1;
        w_pick = v_sel;
      end
    end
  end

  // Next-state and ready logic; the owner's ready is the only combinational output
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_data_nxt  = r_data;
    w_start_nxt = 1'b0;
    req_ready_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_busy_nxt  = 1'b1;
`ifdef UART_ARB_HDR_EN
          w_state_nxt = S_HDR;
`else
          w_state_nxt = S_LOAD;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        // Header goes out through the normal byte sequence; clearing last returns us to LOAD
        if (!tx_busy_i) begin
          w_data_nxt  = w_hdr_byte;
          w_start_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_state_nxt = S_WAIT_HI;
        end
      end
`endif
      S_LOAD: begin
        // Only the owner is served; a stalled owner holds the UART (message lock)
        req_ready_o[r_grant] = w_owner_valid & ~tx_busy_i;
        if (w_owner_valid && !tx_busy_i) begin
          w_data_nxt  = w_owner_data;
          w_start_nxt = 1'b1;
          w_last_nxt  = w_owner_last;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy_i) w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy_i) begin
          if (r_last) begin
            w_ptr_nxt   = w_grant_inc;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial message immediately
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_start <= w_start_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign tx_data_o  = r_data;
  assign tx_start_o = r_start;
  assign grant_o    = r_grant;
  assign busy_o     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter with a simple
//            UART model that stays busy for 10 cycles after each start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int NB  = 8;
  localparam int UBZ = 10;

  logic              sysclk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid_i;
  logic [NR*NB-1:0]  req_data_i;
  logic [NR-1:0]     req_last_i;
  logic [NR-1:0]     req_ready_o;
  logic [NB-1:0]     tx_data_o;
  logic              tx_start_o;
  logic              tx_busy_i;
  logic [1:0]        grant_o;
  logic              busy_o;

  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;
  logic force_busy = 1'b0;

  logic [7:0] log_q[$];
  int   start_cnt  = 0;
  int   start_viol = 0;
  int   rdy_viol   = 0;
  int   rdy_cnt [NR];
  logic prev_start = 1'b0;

  uart_tx_arbiter dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_start_o  (tx_start_o),
    .tx_busy_i   (tx_busy_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 sysclk = ~sysclk;

  // UART model: busy rises the cycle after start and lasts UBZ cycles
  always @(posedge sysclk) begin
    if (tx_start_o) busy_cnt <= UBZ;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy_i = (busy_cnt != 0) || force_busy;

  // Line monitor: logs bytes, counts pulses and checks ready invariants
  initial for (int r = 0; r < NR; r++) rdy_cnt[r] = 0;
  always @(negedge sysclk) begin
    if (tx_start_o) begin
      log_q.push_back(tx_data_o);
      start_cnt++;
      if (prev_start) start_viol++;
    end
    prev_start = tx_start_o;
    for (int r = 0; r < NR; r++) if (req_ready_o[r]) rdy_cnt[r]++;
    if (req_ready_o != '0 && (req_ready_o != (4'b0001 << grant_o) || !busy_o)) rdy_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Offer one byte and return once it is accepted; nw = negedges until ready
  task automatic push_byte(input int r, input logic [7:0] d, input logic lst, output int nw);
    req_valid_i[r]          = 1'b1;
    req_data_i[r*NB +: NB]  = d;
    req_last_i[r]           = lst;
    nw = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      nw++;
      if (req_ready_o[r]) break;
    end
    chk($sformatf("ready_r%0d", r), {31'd0, req_ready_o[r]}, 32'd1);
    @(posedge sysclk);
    #1;
    chk($sformatf("start_r%0d", r), {31'd0, tx_start_o}, 32'd1);
    chk($sformatf("data_r%0d", r), {24'd0, tx_data_o}, {24'd0, d});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      if (!busy_o && !tx_busy_i) break;
      tick(1);
    end
    chk("idle", {30'd0, busy_o, tx_busy_i}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    int sc;
    int r0;
    int rsum;
    reset       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tick(3);

    // Reset values
    chk("rst_start", {31'd0, tx_start_o}, 32'd0);
    chk("rst_data",  {24'd0, tx_data_o}, 32'd0);
    chk("rst_ready", {28'd0, req_ready_o}, 32'd0);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_ptr",   {30'd0, dut.r_ptr}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Single requester 2, three-byte message
    push_byte(2, 8'h11, 1'b0, nw);
    chk("t1_first_lat", nw, 32'd2);
    push_byte(2, 8'h22, 1'b0, nw);
    chk("t1_gap_lat", nw, 32'd13);
    push_byte(2, 8'h33, 1'b1, nw);
    req_valid_i[2] = 1'b0;
    wait_idle();
    chk("t1_ptr", {30'd0, dut.r_ptr}, 32'd3);
    chk("t1_nbytes", log_q.size(), 32'd3);
    chk("t1_b0", {24'd0, log_q[0]}, 32'h11);
    chk("t1_b1", {24'd0, log_q[1]}, 32'h22);
    chk("t1_b2", {24'd0, log_q[2]}, 32'h33);
    chk("t1_rdy2", rdy_cnt[2], 32'd3);
    chk("t1_starts", start_cnt, 32'd3);

    // All four valid from reset: order 0,1,2,3,0,...
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t2_ptr_rst", {30'd0, dut.r_ptr}, 32'd0);
    log_q.delete();
    req_valid_i = 4'b1111;
    req_last_i  = 4'b1111;
    req_data_i  = {8'h43, 8'h42, 8'h41, 8'h40};
    for (int k = 0; k < 600; k++) begin
      if (log_q.size() >= 8) break;
      tick(1);
    end
    req_valid_i = '0;
    chk("t2_nbytes", {31'd0, log_q.size() >= 8}, 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_b%0d", i), {24'd0, log_q[i]}, 32'h40 + (i % 4));
    wait_idle();

    // Owner 1 stalls mid-message while requester 0 waits
    log_q.delete();
    push_byte(1, 8'h61, 1'b0, nw);
    req_valid_i[1] = 1'b0;
    req_valid_i[0] = 1'b1;
    req_data_i[0 +: 8] = 8'h70;
    req_last_i[0]  = 1'b1;
    tick(1);
    sc = start_cnt;
    r0 = rdy_cnt[0];
    tick(50);
    chk("t3_gap_starts", start_cnt, sc);
    chk("t3_gap_rdy0", rdy_cnt[0], r0);
    push_byte(1, 8'h62, 1'b1, nw);
    req_valid_i[1] = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (log_q.size() >= 3) break;
      tick(1);
    end
    req_valid_i[0] = 1'b0;
    chk("t3_b0", {24'd0, log_q[0]}, 32'h61);
    chk("t3_b1", {24'd0, log_q[1]}, 32'h62);
    chk("t3_b2", {24'd0, log_q[2]}, 32'h70);
    chk("t3_rdy0", rdy_cnt[0], r0 + 1);
    wait_idle();

    // External busy holds off the grant's ready and start
    force_busy     = 1'b1;
    req_valid_i[0] = 1'b1;
    req_data_i[0 +: 8] = 8'h5A;
    req_last_i[0]  = 1'b1;
    tick(1);
    sc   = start_cnt;
    rsum = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
    tick(30);
    chk("t4_starts", start_cnt, sc);
    chk("t4_rdy", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3], rsum);
    chk("t4_busy", {31'd0, busy_o}, 32'd1);
    force_busy = 1'b0;
    push_byte(0, 8'h5A, 1'b1, nw);
    req_valid_i[0] = 1'b0;
    chk("t4_release_lat", nw, 32'd1);
    wait_idle();

    // Reset during WAIT_LO of byte 2 of a four-byte message
    push_byte(1, 8'h01, 1'b0, nw);
    push_byte(1, 8'h02, 1'b0, nw);
    tick(4);
    chk("t5_pre_busy", {31'd0, busy_o}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_start", {31'd0, tx_start_o}, 32'd0);
    chk("t5_data",  {24'd0, tx_data_o}, 32'd0);
    chk("t5_ready", {28'd0, req_ready_o}, 32'd0);
    chk("t5_grant", {30'd0, grant_o}, 32'd0);
    chk("t5_busy",  {31'd0, busy_o}, 32'd0);
    chk("t5_ptr",   {30'd0, dut.r_ptr}, 32'd0);
    req_valid_i[1] = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
    tick(1);
    push_byte(3, 8'h77, 1'b1, nw);
    chk("t5_grant3", {30'd0, grant_o}, 32'd3);
    chk("t5_busy3",  {31'd0, busy_o}, 32'd1);
    req_valid_i[3] = 1'b0;
    wait_idle();
    chk("t5_ptr_after", {30'd0, dut.r_ptr}, 32'd0);

    // Single-byte message from 3: header prefix only with the option built in
    log_q.delete();
    push_byte(3, 8'h55, 1'b1, nw);
    req_valid_i[3] = 1'b0;
    wait_idle();
`ifdef UART_ARB_HDR_EN
    chk("t6_nbytes", log_q.size(), 32'd2);
    chk("t6_hdr", {24'd0, log_q[0]}, 32'hA3);
    chk("t6_b0",  {24'd0, log_q[1]}, 32'h55);
`else
    chk("t6_nbytes", log_q.size(), 32'd1);
    chk("t6_b0",  {24'd0, log_q[0]}, 32'h55);
`endif

    chk("start_width", start_viol, 32'd0);
    chk("ready_onehot", rdy_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
